temp_spi_reader: RTL

Consumes the periodic update tick of the temperature-sensor path and performs one SPI mode-0 read of the sensor's temperature word per tick. It drives CS_n/SCLK, shifts in the MISO word MSB first, and presents the result on Dato with a one-cycle Valid strobe for the display and formatting stages downstream. It is the direct consumer of the update-rate counter's terminal-count pulse.

---
 rtl/temp_spi_reader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/temp_spi_reader.sv
// temp_spi_reader
// Performs one SPI mode-0 read of the temperature sensor for every update
// Tick. It drives CS_n and SCLK, shifts MISO in MSB first on each SCLK
// rising edge, and presents the finished word on Dato. Valid is a one-cycle
// strobe in the same cycle that Dato is updated.
//
// Optional feature (macro TEMP_SPI_AVG_EN):
//   When defined, Dato is the floor average of the last four raw words,
//   treated as signed. The first read after reset fills the whole history.
//   When undefined, Dato is the raw word and no history registers exist.
//
// Parameters:
//   DIV   - SCLK half-period in CLK cycles (2..255)
//   NBITS - bits per read word (8..32)
// Ports:
//   CLK   in   system clock, all logic on posedge
//   Rst   in   synchronous active-high reset
//   Tick  in   one-cycle update request (ignored while Busy)
//   MISO  in   sensor serial data
//   CS_n  out  sensor chip select, active low
//   SCLK  out  serial clock, registered, idle low
//   Dato  out  last completed reading (raw or averaged)
//   Valid out  one-cycle strobe when Dato updates
//   Busy  out  high from Tick acceptance until the end of HOLD
module temp_spi_reader #(
   parameter int DIV   = 25,
   parameter int NBITS = 16
) (
   input  logic             CLK,
   input  logic             Rst,
   input  logic             Tick,
   input  logic             MISO,
   output logic             CS_n,
   output logic             SCLK,
   output logic [NBITS-1:0] Dato,
   output logic             Valid,
   output logic             Busy
);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
   localparam logic [5:0] BIT_LAST = 6'(NBITS - 1);

   state_t           state_q;
   logic [7:0]       div_cnt_q;
   logic [5:0]       bit_cnt_q;
   logic [NBITS-1:0] shift_q;
   logic [NBITS-1:0] dato_d;

`ifdef TEMP_SPI_AVG_EN
   logic [NBITS-1:0] hist_q [3];
   logic             hist_vld_q;

   // Signed floor average of four words: sum in NBITS+2 bits, arithmetic
   // shift by two, truncate back to NBITS.
   function automatic logic [NBITS-1:0] avg4(input logic [NBITS-1:0] a,
                                             input logic [NBITS-1:0] b,
                                             input logic [NBITS-1:0] c,
                                             input logic [NBITS-1:0] d);
      logic signed [NBITS+1:0] sum;
      logic signed [NBITS+1:0] shr;
      sum = $signed({{2{a[NBITS-1]}}, a}) + $signed({{2{b[NBITS-1]}}, b})
          + $signed({{2{c[NBITS-1]}}, c}) + $signed({{2{d[NBITS-1]}}, d});
      shr = sum >>> 2;
      return shr[NBITS-1:0];
   endfunction

   // Until the history holds a word, the new word stands for all four
   // entries, whose average is the word itself.
   always_comb begin
      dato_d = shift_q;
      if (hist_vld_q)
         dato_d = avg4(shift_q, hist_q[0], hist_q[1], hist_q[2]);
   end
`else
   assign dato_d = shift_q;
`endif

   always_ff @(posedge CLK) begin
      if (Rst) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         CS_n      <= 1'b1;
         SCLK      <= 1'b0;
         Dato      <= '0;
         Valid     <= 1'b0;
         Busy      <= 1'b0;
`ifdef TEMP_SPI_AVG_EN
         hist_vld_q <= 1'b0;
         for (int i = 0; i < 3; i++) hist_q[i] <= '0;
`endif
      end else begin
         Valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Tick) begin
                  state_q   <= SETUP;
                  CS_n      <= 1'b0;
                  Busy      <= 1'b1;
                  div_cnt_q <= '0;
                  bit_cnt_q <= '0;
               end
            end
            SETUP: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  state_q   <= SHIFT;
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            SHIFT: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  SCLK      <= ~SCLK;
                  if (!SCLK) begin
                     // SCLK rising on this edge: sample the stable MISO bit
                     shift_q <= {shift_q[NBITS-2:0], MISO};
                  end else if (bit_cnt_q == BIT_LAST) begin
                     // Falling edge ending the last period leaves SCLK low
                     state_q <= HOLD;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            HOLD: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= IDLE;
                  CS_n      <= 1'b1;
                  Busy      <= 1'b0;
                  Valid     <= 1'b1;
                  Dato      <= dato_d;
`ifdef TEMP_SPI_AVG_EN
                  hist_vld_q <= 1'b1;
                  if (hist_vld_q) begin
                     hist_q[0] <= shift_q;
                     hist_q[1] <= hist_q[0];
                     hist_q[2] <= hist_q[1];
                  end else begin
                     for (int i = 0; i < 3; i++) hist_q[i] <= shift_q;
                  end
`endif
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
